// File: rtl/gf_mul.sv
// gf_mul: bit-serial MSB-first interleaved modular multiplier, result = a*b mod p (or a*a mod p)
module gf_mul #(
   parameter int N = 256
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] p,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         mode_select,
   input  logic         start,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result_mul
);
   localparam int CW = $clog2(N);
   typedef enum logic {IDLE, RUN} state_t;
   state_t         state_q, state_d;
   logic [N-1:0]   p_q, p_d, a_q, a_d, m_q, m_d, acc_q, acc_d, res_q, res_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           done_q, done_d;
   logic [N:0]     t, t_r, u, u_r;
   // acc < p holds every step, so one conditional subtract after doubling and after adding is enough
   always_comb begin
      t   = {acc_q, 1'b0};
      t_r = (t >= {1'b0, p_q}) ? t - {1'b0, p_q} : t;
      u   = t_r + (m_q[cnt_q] ? {1'b0, a_q} : '0);
      u_r = (u >= {1'b0, p_q}) ? u - {1'b0, p_q} : u;
   end
   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      a_d     = a_q;
      m_d     = m_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      done_d  = 1'b0;
      if (state_q == IDLE) begin
         if (start) begin
            p_d     = p;
            a_d     = a;
            m_d     = mode_select ? a : b;
            acc_d   = '0;
            cnt_d   = CW'(N - 1);
            state_d = RUN;
         end
      end else begin
         acc_d = u_r[N-1:0];
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == '0) begin
            res_d   = u_r[N-1:0];
            done_d  = 1'b1;
            state_d = IDLE;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         p_q     <= '0;
         a_q     <= '0;
         m_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         a_q     <= a_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end
   assign busy       = (state_q == RUN);
   assign done       = done_q;
   assign result_mul = res_q;
endmodule

// File: tb/tb_gf_mul.sv
// tb_gf_mul: directed and random checks of gf_mul (N=256) against a wide-arithmetic reference model
module tb_gf_mul;
   localparam int N = 256;
   logic         clk = 1'b0;
   logic         rst, mode_select, start, busy, done;
   logic [N-1:0] p, a, b, result_mul;
   int           total = 0;
   int           bad = 0;
   localparam logic [N-1:0] SECP = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

   gf_mul #(.N(N)) dut (
      .clk(clk), .rst(rst), .p(p), .a(a), .b(b), .mode_select(mode_select),
      .start(start), .busy(busy), .done(done), .result_mul(result_mul)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] rnd();
      logic [N-1:0] r = '0;
      for (int i = 0; i < N / 32; i++) r = {r[N-33:0], 32'($urandom())};
      return r;
   endfunction

   function automatic logic [N-1:0] ref_mul(input logic [N-1:0] m, input logic [N-1:0] x, input logic [N-1:0] y);
      logic [2*N-1:0] pr;
      pr = {{N{1'b0}}, x} * {{N{1'b0}}, y};
      return N'(pr % {{N{1'b0}}, m});
   endfunction

   task automatic start_op(input logic [N-1:0] pp, input logic [N-1:0] aa, input logic [N-1:0] bb, input logic md);
      p = pp; a = aa; b = bb; mode_select = md; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      p = rnd(); a = rnd(); b = rnd(); mode_select = ~md;
      chk("accept_busy", N'(busy), N'(1'b1));
      chk("accept_done", N'(done), N'(1'b0));
   endtask

   task automatic wait_done(input string tag, input int n0, input logic [N-1:0] exp);
      int n = n0;
      while (done !== 1'b1 && n < N + 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_latency"}, N'(n), N'(N));
      chk({tag, "_result"}, result_mul, exp);
      chk({tag, "_busy_low"}, N'(busy), N'(1'b0));
   endtask

   task automatic idle_check(input string tag, input logic [N-1:0] exp);
      @(posedge clk); #1;
      chk({tag, "_done_width"}, N'(done), N'(1'b0));
      chk({tag, "_held"}, result_mul, exp);
   endtask

   initial begin
      logic [N-1:0] rp, ra, rb, ex;
      logic         rm;
      rst = 1'b1; start = 1'b0; p = '0; a = '0; b = '0; mode_select = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", N'(busy), N'(1'b0));
      chk("reset_done", N'(done), N'(1'b0));
      chk("reset_result", result_mul, '0);
      rst = 1'b0;
      @(posedge clk); #1;

      start_op(251, 3, 5, 1'b0);       wait_done("p251_3x5", 0, 15);       idle_check("p251_3x5", 15);
      start_op(251, 250, 250, 1'b0);   wait_done("p251_250sq", 0, 1);      idle_check("p251_250sq", 1);
      start_op(251, 0, 77, 1'b0);      wait_done("p251_zero", 0, 0);       idle_check("p251_zero", 0);
      start_op(251, 16, 99, 1'b1);     wait_done("p251_square16", 0, 5);   idle_check("p251_square16", 5);
      start_op(SECP, SECP - 1, SECP - 1, 1'b0); wait_done("secp_m1sq", 0, 1); idle_check("secp_m1sq", 1);
      start_op(SECP, 2, (SECP >> 1) + 1, 1'b0); wait_done("secp_half", 0, 1); idle_check("secp_half", 1);

      // a second start mid-run must not disturb the running product
      ra = rnd() % SECP; rb = rnd() % SECP;
      start_op(SECP, ra, rb, 1'b0);
      repeat (49) begin @(posedge clk); #1; end
      p = 251; a = 7; b = 9; mode_select = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("restart_ignored", 50, ref_mul(SECP, ra, rb));

      start_op(SECP, ra, rb, 1'b1);
      repeat (99) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_busy", N'(busy), N'(1'b0));
      chk("midrst_done", N'(done), N'(1'b0));
      chk("midrst_result", result_mul, '0);
      idle_check("midrst_quiet", '0);

      start_op(SECP, ra, rb, 1'b1);
      wait_done("after_rst", 0, ref_mul(SECP, ra, ra));
      start_op(251, 250, 3, 1'b0);
      wait_done("back_to_back", 0, 250 * 3 % 251);
      idle_check("back_to_back", 250 * 3 % 251);

      for (int i = 0; i < 60; i++) begin
         rp = (i % 2 == 0) ? SECP : (rnd() | 256'h1);
         if (i % 4 == 3) rp = rp >> $urandom_range(N - 8);
         rp = rp | 256'h5;
         ra = rnd() % rp; rb = rnd() % rp; rm = 1'($urandom());
         ex = ref_mul(rp, ra, rm ? ra : rb);
         start_op(rp, ra, rb, rm);
         wait_done($sformatf("rand%0d", i), 0, ex);
         if (i % 3 == 0) idle_check($sformatf("rand%0d", i), ex);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
